// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Line-configuration encodings, receive/transmit FSM state
//                codes and the data-width decode helper shared by the UART
//                RX and TX controllers.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Data-width select encodings (number of data bits per frame)
    localparam logic [1:0] c_width_5 = 2'b00;
    localparam logic [1:0] c_width_6 = 2'b01;
    localparam logic [1:0] c_width_7 = 2'b10;
    localparam logic [1:0] c_width_8 = 2'b11;

    // Parity select encodings; 2'b01 is an alias for "no parity"
    localparam logic [1:0] c_par_none     = 2'b00;
    localparam logic [1:0] c_par_none_alt = 2'b01;
    localparam logic [1:0] c_par_odd      = 2'b10;
    localparam logic [1:0] c_par_even     = 2'b11;

    // Stop-bit select encodings
    localparam logic c_stop_one = 1'b0;
    localparam logic c_stop_two = 1'b1;

    // Receiver FSM state codes
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_start      = 3'd1;
    localparam logic [2:0] c_st_data       = 3'd2;
    localparam logic [2:0] c_st_parity     = 3'd3;
    localparam logic [2:0] c_st_stop       = 3'd4;
    localparam logic [2:0] c_st_commit     = 3'd5;
    localparam logic [2:0] c_st_break_wait = 3'd6;

    // Encoded width select -> number of data bits (5..8)
    function automatic logic [3:0] width_decode(input logic [1:0] enc);
        return 4'd5 + {2'b00, enc};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_controller_if
//  Description : Line-config bus and RX FIFO write port between the UART
//                receive engine (slave) and its host/FIFO side (master).
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_controller_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int DATA_WIDTH_OPTION_W = 2,
    parameter int PARITY_OPTION_W     = 2,
    parameter int STOP_BIT_OPTION_W   = 1
);
    // Line configuration, shared with the TX side
    logic [DATA_WIDTH_OPTION_W-1:0] data_width_option;
    logic [PARITY_OPTION_W-1:0]     parity_option;
    logic [STOP_BIT_OPTION_W-1:0]   stop_bit_option;

    // FIFO write port and status strobes
    logic                           fifo_full;
    logic [DATA_WIDTH-1:0]          data_out;
    logic                           fifo_wr;
    logic                           parity_error;
    logic                           frame_error;
    logic                           overrun_error;
    logic                           rx_busy;

    modport master (
        output data_width_option, parity_option, stop_bit_option, fifo_full,
        input  data_out, fifo_wr, parity_error, frame_error, overrun_error, rx_busy
    );

    modport slave (
        input  data_width_option, parity_option, stop_bit_option, fifo_full,
        output data_out, fifo_wr, parity_error, frame_error, overrun_error, rx_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous RX pad. Resets to
//                the idle (high) line level so no false start is seen after
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic rx_async,
    output logic      rx_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation of the pad into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx_async;
            r_sync <= r_meta;
        end
    end

    assign rx_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_controller
//  Description : UART receive engine. Oversamples the synchronised RX line
//                on baud_tick_en, de-frames start/data/parity/stop and writes
//                each good word into the RX FIFO with a one-cycle strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int OVERSAMPLE          = 16,
    parameter int DATA_WIDTH_OPTION_W = 2,
    parameter int PARITY_OPTION_W     = 2,
    parameter int STOP_BIT_OPTION_W   = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             RX,
    input  wire logic             baud_tick_en,
    uart_rx_controller_if.slave   bus
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w  = $clog2(DATA_WIDTH);

    // Tick counts at which the start bit and the following bits are sampled
    localparam logic [c_tick_w-1:0] c_half_m1 = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_full_m1 = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [3:0]          c_dw      = 4'(DATA_WIDTH);

    logic                  w_rx_s;

    logic [2:0]            r_state;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_width;
    logic                  r_par_en;
    logic                  r_par_odd;
    logic                  r_stop_left;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_fifo_wr;
    logic                  r_perr_pulse;
    logic                  r_ferr_pulse;
    logic                  r_ovr_pulse;

    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [3:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_aligned;
    logic                  w_par_expect;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_async (RX),
        .rx_sync  (w_rx_s)
    );

    // Bits arrive LSB first and are shifted in at the MSB end; once the
    // last bit is in, the word is shifted down so it sits LSB-aligned with
    // zeros above it (the shift register starts cleared each frame).
    assign w_shift_next = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
    assign w_shamt      = c_dw - r_width;
    assign w_aligned    = w_shift_next >> w_shamt;

    // Expected parity bit: odd makes the total count of ones odd
    assign w_par_expect = r_par_odd ? ~(^r_data) : (^r_data);

    // Frame sequencer: start qualification, bit sampling and frame tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_width     <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_stop_left <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (baud_tick_en && !w_rx_s) begin
                        r_state    <= c_st_start;
                        r_tick_cnt <= '0;
                    end
                end

                c_st_start: begin
                    if (baud_tick_en) begin
                        if (r_tick_cnt == c_half_m1) begin
                            r_tick_cnt <= '0;
                            if (!w_rx_s) begin
                                // Real start bit: freeze the line config for this frame
                                r_state     <= c_st_data;
                                r_busy      <= 1'b1;
                                r_width     <= width_decode(bus.data_width_option);
                                r_bit_cnt   <= c_bit_w'(width_decode(bus.data_width_option) - 4'd1);
                                r_par_en    <= bus.parity_option[1];
                                r_par_odd   <= (bus.parity_option == c_par_odd);
                                r_stop_left <= (bus.stop_bit_option[0] == c_stop_two);
                                r_shift     <= '0;
                                r_perr      <= 1'b0;
                                r_ferr      <= 1'b0;
                            end else begin
                                // Line back high at mid-start: a glitch, ignore it
                                r_state <= c_st_idle;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                c_st_data: begin
                    if (baud_tick_en) begin
                        if (r_tick_cnt == c_full_m1) begin
                            r_tick_cnt <= '0;
                            r_shift    <= w_shift_next;
                            if (r_bit_cnt == '0) begin
                                r_data  <= w_aligned;
                                r_state <= r_par_en ? c_st_parity : c_st_stop;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                c_st_parity: begin
                    if (baud_tick_en) begin
                        if (r_tick_cnt == c_full_m1) begin
                            r_tick_cnt <= '0;
                            r_perr     <= (w_rx_s != w_par_expect);
                            r_state    <= c_st_stop;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                c_st_stop: begin
                    if (baud_tick_en) begin
                        if (r_tick_cnt == c_full_m1) begin
                            r_tick_cnt <= '0;
                            if (!w_rx_s) begin
                                // A low stop bit ends the frame; later stop bits are not examined
                                r_ferr  <= 1'b1;
                                r_state <= c_st_commit;
                            end else if (r_stop_left) begin
                                r_stop_left <= 1'b0;
                            end else begin
                                r_state <= c_st_commit;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                c_st_commit: begin
                    r_busy  <= 1'b0;
                    r_state <= r_ferr ? c_st_break_wait : c_st_idle;
                end

                c_st_break_wait: begin
                    // A line held low (break) must return high before a new start is hunted
                    if (w_rx_s) begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Commit stage: write the word or raise exactly one error strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_fifo_wr    <= 1'b0;
            r_perr_pulse <= 1'b0;
            r_ferr_pulse <= 1'b0;
            r_ovr_pulse  <= 1'b0;
        end else begin
            r_fifo_wr    <= 1'b0;
            r_perr_pulse <= 1'b0;
            r_ferr_pulse <= 1'b0;
            r_ovr_pulse  <= 1'b0;
            if (r_state == c_st_commit) begin
                if (r_ferr) begin
                    r_ferr_pulse <= 1'b1;
                end else if (bus.fifo_full) begin
                    r_ovr_pulse <= 1'b1;
                end else begin
                    // A parity error still delivers the word, flagged alongside it
                    r_fifo_wr    <= 1'b1;
                    r_data_out   <= r_data;
                    r_perr_pulse <= r_perr;
                end
            end
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.fifo_wr       = r_fifo_wr;
    assign bus.parity_error  = r_perr_pulse;
    assign bus.frame_error   = r_ferr_pulse;
    assign bus.overrun_error = r_ovr_pulse;
    assign bus.rx_busy       = r_busy;

endmodule
`default_nettype wire
